regfile_mp: RTL
===============

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register width in bits.
REQ-002 Parameter ADDR_W, default 5, SHALL set the register count to 2**ADDR_W.
REQ-003 Parameter NRD, default 2, SHALL set the number of read ports (range 1..4).
REQ-004 Parameter ZERO_REG, default 1, SHALL, when 1, hardwire register 0 to zero.
REQ-005 clk  input  1  clock, all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 rd_addr  input  NRD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-008 rd_data  output  NRD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W].
REQ-009 rd_busy  output  NRD  pending flag of the register addressed by each read port.
REQ-010 wa_en, wa_addr, wa_data  input  1/ADDR_W/DATA_W  write port A.
REQ-011 wb_en, wb_addr, wb_data  input  1/ADDR_W/DATA_W  write port B.
REQ-012 iss_en, iss_addr  input  1/ADDR_W  issue: mark a register pending.
REQ-013 busy_cnt  output  ADDR_W+1  number of registers currently pending.

Function
REQ-014 Reads SHALL be combinational: rd_data reflects register contents in the same cycle.
REQ-015 Writes SHALL commit on the rising clk edge when the port enable is high.
REQ-016 Write-through bypass: a read whose address matches an enabled write in the same cycle SHALL return that write's data.
REQ-017 Ports A and B writing the same address in one cycle: port B data SHALL be stored and bypassed.
REQ-018 iss_en high SHALL set the pending bit of iss_addr at the next edge.
REQ-019 An enabled write on either port SHALL clear the pending bit of its address at the next edge.
REQ-020 Issue and write to the same address in one cycle: the pending bit SHALL end set (new producer wins).
REQ-021 Read-side rd_busy SHALL reflect the registered pending bit, except it SHALL read 0 when an enabled write to that address occurs in the same cycle and no issue targets it.
REQ-022 busy_cnt SHALL equal the population count of the pending vector, updated with it, never exceeding 2**ADDR_W.
REQ-023 ZERO_REG=1: writes and issues to address 0 SHALL be ignored; rd_data SHALL be 0 and rd_busy 0 for address 0, bypass included.
REQ-024 ZERO_REG=0: register 0 SHALL behave as any other register.
REQ-025 Writes with en low SHALL have no effect on data or pending state.

Reset
REQ-026 rst low SHALL immediately clear all registers to 0, all pending bits to 0 and busy_cnt to 0, regardless of clk.
REQ-027 rst low SHALL override any write or issue in the same cycle; mid-operation reset SHALL lose no determinism (all state zero on release).
REQ-028 First write/issue after reset release SHALL take effect at the first rising edge with rst high.

Structure
REQ-029 Package regfile_pkg SHALL hold default DATA_W, ADDR_W, NRD constants and a function for popcount width.
REQ-030 One sub-module, regfile_rdport (single read port: array select, two-port bypass, zero-register masking, busy output), SHALL be instantiated NRD times via generate.
REQ-031 Storage SHALL be a flop array of 2**ADDR_W entries; no latches, no inferred memory macros.

Verification
REQ-032 Reset: write 0xDEADBEEF to r5, assert rst mid-cycle -> rd_data for r5 reads 0 immediately, busy_cnt=0.
REQ-033 Bypass: wa_en=1, wa_addr=7, wa_data=0x1234, rd_addr port0=7 same cycle -> rd_data port0=0x1234 before the edge and after it.
REQ-034 Conflict: A writes r3=0x11, B writes r3=0x22 same cycle -> r3=0x22 after edge.
REQ-035 Zero register: write r0=0xFFFFFFFF, issue r0 -> rd_data=0, rd_busy=0, busy_cnt=0.
REQ-036 Scoreboard: issue r4, r9 in consecutive cycles -> busy_cnt=2; write r4 with issue r4 same cycle -> r4 stays pending, busy_cnt=2; write r9 -> busy_cnt=1.
REQ-037 Random: 10k cycles random writes/issues/reads on all ports checked against a reference model, including all-registers-pending (busy_cnt=31 with ZERO_REG=1).

Source files
------------

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared defaults for the multi-port register file and a helper that sizes
// the pending-register counter.
//   DEF_DATA_W : default register width in bits
//   DEF_ADDR_W : default address width (2**DEF_ADDR_W registers)
//   DEF_NRD    : default number of combinational read ports
//   cnt_width  : bits needed to count 0 .. 2**addr_w pending registers
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NRD    = 2;

    // A full count of 2**addr_w needs one bit more than the address.
    function automatic int cnt_width(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// ---------------------------------------------------------------------------
// regfile_rdport
// One combinational read port of the register file.
//   addr                 : register being read
//   regs, pending        : registered contents and pending bits of all entries
//   wa_*, wb_*           : the two write ports, used for write-through bypass
//   iss_en, iss_addr     : issue port, keeps a re-issued register busy
//   data                 : read data (bypassed, zero-register masked)
//   busy                 : pending flag of the addressed register
// ---------------------------------------------------------------------------
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1
)(
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] regs [2**ADDR_W],
    input  logic [2**ADDR_W-1:0] pending,
    input  logic              wa_en,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [DATA_W-1:0] wa_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic [DATA_W-1:0] data,
    output logic              busy
);

    logic hit_a;
    logic hit_b;
    logic hit_iss;
    logic is_zero;

    assign hit_a   = wa_en  && (wa_addr  == addr);
    assign hit_b   = wb_en  && (wb_addr  == addr);
    assign hit_iss = iss_en && (iss_addr == addr);
    assign is_zero = (ZERO_REG != 0) && (addr == '0);

    // Port B is checked last so it wins a same-address conflict, matching
    // the value that will actually be stored at the edge.
    always_comb begin
        data = regs[addr];
        if (hit_a) begin
            data = wa_data;
        end
        if (hit_b) begin
            data = wb_data;
        end
        if (is_zero) begin
            data = '0;
        end
    end

    // A write landing this cycle retires the producer early, unless a new
    // issue to the same register is replacing it in the same cycle.
    always_comb begin
        busy = pending[addr];
        if ((hit_a || hit_b) && !hit_iss) begin
            busy = 1'b0;
        end
        if (is_zero) begin
            busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
// Multi-port register file with per-register pending (scoreboard) bits.
//   clk, rst           : clock, asynchronous active-low reset
//   rd_addr / rd_data  : NRD packed combinational read ports
//   rd_busy            : pending flag of each read port's register
//   wa_*, wb_*         : two write ports, B wins on address conflict
//   iss_en, iss_addr   : marks a register pending at the next edge
//   busy_cnt           : number of registers currently pending
// ---------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NRD      = DEF_NRD,
    parameter int ZERO_REG = 1
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NRD*ADDR_W-1:0]    rd_addr,
    output logic [NRD*DATA_W-1:0]    rd_data,
    output logic [NRD-1:0]           rd_busy,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic [cnt_width(ADDR_W)-1:0] busy_cnt
);

    localparam int NREG  = 2**ADDR_W;
    localparam int CNT_W = cnt_width(ADDR_W);

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pend_next;
    logic [CNT_W-1:0]  cnt_next;

    logic wa_ok;
    logic wb_ok;
    logic iss_ok;

    // With a hardwired zero register, anything aimed at address 0 is dropped
    // before it reaches the storage or the pending vector.
    assign wa_ok  = wa_en  && !((ZERO_REG != 0) && (wa_addr  == '0));
    assign wb_ok  = wb_en  && !((ZERO_REG != 0) && (wb_addr  == '0));
    assign iss_ok = iss_en && !((ZERO_REG != 0) && (iss_addr == '0));

    // Register storage; port B is assigned last so it wins a conflict.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wa_ok) begin
                regs[wa_addr] <= wa_data;
            end
            if (wb_ok) begin
                regs[wb_addr] <= wb_data;
            end
        end
    end

    // Writes retire producers, then the issue is applied so a new producer
    // on the same register keeps it pending.
    always_comb begin
        pend_next = pending;
        if (wa_ok) begin
            pend_next[wa_addr] = 1'b0;
        end
        if (wb_ok) begin
            pend_next[wb_addr] = 1'b0;
        end
        if (iss_ok) begin
            pend_next[iss_addr] = 1'b1;
        end
    end

    // Population count of the next pending vector, registered alongside it
    // so busy_cnt always matches the registered pending bits.
    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_next = cnt_next + CNT_W'(pend_next[i]);
        end
    end

    // Pending vector and its count share one asynchronously reset register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending  <= '0;
            busy_cnt <= '0;
        end else begin
            pending  <= pend_next;
            busy_cnt <= cnt_next;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        regfile_rdport #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rdport (
            .addr     (rd_addr[k*ADDR_W +: ADDR_W]),
            .regs     (regs),
            .pending  (pending),
            .wa_en    (wa_en),
            .wa_addr  (wa_addr),
            .wa_data  (wa_data),
            .wb_en    (wb_en),
            .wb_addr  (wb_addr),
            .wb_data  (wb_data),
            .iss_en   (iss_en),
            .iss_addr (iss_addr),
            .data     (rd_data[k*DATA_W +: DATA_W]),
            .busy     (rd_busy[k])
        );
    end

endmodule
